// File: rtl/ll_control.sv
// Lunar lander control: step-rate write-enable, keypad sync/edge-detect, thrust and
// display registers, and the touchdown landed/crashed decision.
module ll_control #(
    parameter int          TICK_DIV    = 25,
    parameter logic [15:0] THRUST_INIT = 16'h5,
    parameter logic [15:0] VEL_LIMIT   = 16'h9970,
    parameter logic [15:0] THRUST_MAX  = 16'h5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  key_digit,
    input  logic [3:0]  key_sel,
    input  logic [15:0] alt,
    input  logic [15:0] vel,
    input  logic [15:0] thrust,
    input  logic [15:0] alt_n,
    output logic        wen,
    output logic [15:0] thrust_n,
    output logic [1:0]  disp_sel,
    output logic        flying,
    output logic        landed,
    output logic        crashed
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    localparam logic [1:0] S_FLY     = 2'd0;
    localparam logic [1:0] S_LANDED  = 2'd1;
    localparam logic [1:0] S_CRASHED = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_tick;
    logic [15:0]   r_thrust_n;
    logic [1:0]    r_disp_sel;
    logic [13:0]   r_key_s1;
    logic [13:0]   r_key_s2;
    logic [13:0]   r_key_s3;

    logic [13:0]   w_strobe;
    logic [9:0]    w_dig_stb;
    logic [3:0]    w_sel_stb;
    logic [3:0]    w_dig_val;
    logic [1:0]    w_disp_nxt;
    logic          w_wen;
    logic          w_vel_crash;
    logic          w_thr_crash;
    logic          w_unused;

    // Altitude is only shown on the display; the decision uses the ALU's next altitude.
    assign w_unused = ^alt;

    assign w_strobe  = r_key_s2 & ~r_key_s3;
    assign w_dig_stb = w_strobe[9:0];
    assign w_sel_stb = w_strobe[13:10];

    // Ascending scan so the highest pressed digit is the one that sticks.
    always_comb begin
        w_dig_val = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (w_dig_stb[i]) w_dig_val = 4'(i);
        end
    end

    always_comb begin
        w_disp_nxt = r_disp_sel;
        if (w_sel_stb[0]) w_disp_nxt = 2'd3;
        if (w_sel_stb[1]) w_disp_nxt = 2'd2;
        if (w_sel_stb[2]) w_disp_nxt = 2'd1;
        if (w_sel_stb[3]) w_disp_nxt = 2'd0;
    end

    assign w_wen       = (r_state == S_FLY) && (r_tick == TICK_LAST);
    // Negative BCD velocities live at 5000..9999; unsigned compare on the encoding.
    assign w_vel_crash = (vel >= 16'h5000) && (vel <= VEL_LIMIT);
    assign w_thr_crash = thrust > THRUST_MAX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_s1 <= '0;
            r_key_s2 <= '0;
            r_key_s3 <= '0;
        end else begin
            r_key_s1 <= {key_sel, key_digit};
            r_key_s2 <= r_key_s1;
            r_key_s3 <= r_key_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= '0;
        end else if (r_tick == TICK_LAST) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thrust_n <= THRUST_INIT;
            r_disp_sel <= 2'd0;
        end else begin
            if (|w_dig_stb) r_thrust_n <= {12'h000, w_dig_val};
            r_disp_sel <= w_disp_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FLY;
        end else if (w_wen && (alt_n == 16'h0000)) begin
            r_state <= (w_vel_crash || w_thr_crash) ? S_CRASHED : S_LANDED;
        end
    end

    assign wen      = w_wen;
    assign thrust_n = r_thrust_n;
    assign disp_sel = r_disp_sel;
    assign flying   = (r_state == S_FLY);
    assign landed   = (r_state == S_LANDED);
    assign crashed  = (r_state == S_CRASHED);

endmodule

// File: tb/tb_ll_control.sv
// Bench for ll_control: directed scenarios then random keys/touchdowns/resets,
// compared every cycle against an edge-history reference model.
module tb_ll_control;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  key_digit;
    logic [3:0]  key_sel;
    logic [15:0] alt, vel, thrust, alt_n;
    logic        wen, flying, landed, crashed;
    logic [15:0] thrust_n;
    logic [1:0]  disp_sel;

    int n_cmp = 0;
    int n_err = 0;

    ll_control #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .key_digit(key_digit), .key_sel(key_sel),
        .alt(alt), .vel(vel), .thrust(thrust), .alt_n(alt_n),
        .wen(wen), .thrust_n(thrust_n), .disp_sel(disp_sel),
        .flying(flying), .landed(landed), .crashed(crashed)
    );

    always #5 clk = ~clk;

    // Reference model: edges since reset, game status, key samples per edge.
    int          m_edges;
    int          m_status;   // 0 flying, 1 landed, 2 crashed
    logic [15:0] m_thrust;
    logic [1:0]  m_disp;
    logic [13:0] m_samp[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [13:0] samp(input int e);
        if (e < 1) return 14'h0;
        return m_samp[e-1];
    endfunction

    function automatic logic exp_wen();
        return (m_status == 0) && (m_edges % TD == TD - 1);
    endfunction

    task automatic model_reset();
        m_edges  = 0;
        m_status = 0;
        m_thrust = 16'h5;
        m_disp   = 2'd0;
        m_samp.delete();
    endtask

    task automatic model_edge();
        int          e;
        int          v;
        logic [13:0] stb;
        e = m_edges + 1;
        if (exp_wen() && alt_n == 16'h0) begin
            v = bcd2int(vel);
            if (v >= 5000) v = v - 10000;
            m_status = (v <= -30 || bcd2int(thrust) > 5) ? 2 : 1;
        end
        m_samp.push_back({key_sel, key_digit});
        // A key counts as pressed on the edge two after it was first seen high.
        stb = samp(e - 2) & ~samp(e - 3);
        for (int d = 0; d < 10; d++)
            if (stb[d]) m_thrust = 16'(d);
        if (stb[10]) m_disp = 2'd3;
        if (stb[11]) m_disp = 2'd2;
        if (stb[12]) m_disp = 2'd1;
        if (stb[13]) m_disp = 2'd0;
        m_edges = e;
    endtask

    task automatic check_all();
        chk("wen",      {15'h0, wen},      {15'h0, exp_wen()});
        chk("thrust_n", thrust_n,          m_thrust);
        chk("disp_sel", {14'h0, disp_sel}, {14'h0, m_disp});
        chk("flying",   {15'h0, flying},   {15'h0, m_status == 0});
        chk("landed",   {15'h0, landed},   {15'h0, m_status == 1});
        chk("crashed",  {15'h0, crashed},  {15'h0, m_status == 2});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Called just after a falling edge: reset lands mid-cycle, asynchronously.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rand_bcd();
        return {4'($urandom_range(9)), 4'($urandom_range(9)),
                4'($urandom_range(9)), 4'($urandom_range(9))};
    endfunction

    task automatic rand_inputs();
        logic [15:0] vt [10];
        vt = '{16'h9970, 16'h9980, 16'h9969, 16'h9971, 16'h5000,
               16'h4999, 16'h0000, 16'h9999, 16'h0150, 16'h9500};
        case ($urandom_range(4))
            0: key_digit = 10'h0;
            1: key_digit = (10'h1 << $urandom_range(9)) | (10'h1 << $urandom_range(9));
            default: ;
        endcase
        case ($urandom_range(5))
            0: key_sel = 4'h0;
            1: key_sel = 4'($urandom_range(15));
            default: ;
        endcase
        alt_n  = ($urandom_range(11) == 0) ? 16'h0 : rand_bcd();
        if (alt_n == 16'h0 && $urandom_range(11) != 0) alt_n = 16'h0001;
        vel    = ($urandom_range(1) == 0) ? vt[$urandom_range(9)] : rand_bcd();
        thrust = {12'h0, 4'($urandom_range(9))};
        alt    = rand_bcd();
    endtask

    initial begin
        rst = 1'b1;
        key_digit = '0; key_sel = '0;
        alt = 16'h4500; vel = 16'h0000; thrust = 16'h5; alt_n = 16'h4500;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Free-running steps while flying.
        repeat (13) cycle();

        // Single digit presses, then two digits together.
        key_digit = 10'h200; cycle();
        key_digit = 10'h000; cycle(); cycle();
        chk("thr9", thrust_n, 16'h9);
        key_digit = 10'h008; cycle();
        key_digit = 10'h000; cycle(); cycle();
        chk("thr3", thrust_n, 16'h3);
        key_digit = 10'h084; cycle();
        key_digit = 10'h000; repeat (3) cycle();
        chk("thr7", thrust_n, 16'h7);

        // Y and W together, then held.
        key_sel = 4'b0101;
        repeat (50) cycle();
        chk("disp_hold", {14'h0, disp_sel}, 16'h1);
        key_sel = 4'b0000;
        async_reset();

        // Soft touchdown.
        alt_n = 16'h0; vel = 16'h9980; thrust = 16'h5;
        repeat (2 * TD + 2) cycle();
        chk("landed_dir", {15'h0, landed}, 16'h1);
        async_reset();

        // Velocity right at the limit crashes.
        vel = 16'h9970;
        repeat (2 * TD + 2) cycle();
        chk("crash_vel", {15'h0, crashed}, 16'h1);
        async_reset();
        repeat (TD + 1) cycle();
        async_reset();

        // Thrust above the limit crashes.
        vel = 16'h0000; thrust = 16'h6;
        repeat (2 * TD + 2) cycle();
        chk("crash_thr", {15'h0, crashed}, 16'h1);
        async_reset();
        alt_n = 16'h4500;
        repeat (3) cycle();
        async_reset();

        for (int i = 0; i < 2500; i++) begin
            rand_inputs();
            cycle();
            if ($urandom_range(99) == 0 || (m_status != 0 && $urandom_range(7) == 0))
                async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
